// File: rtl/mesh_wormhole_out_arbiter.sv
// mesh_wormhole_out_arbiter
//   Per-output-port switch allocator for a 2D-mesh wormhole XY NoC node. A matrix
//   arbiter picks one of IN_N inputs presenting a HEAD flit. The grant is then locked
//   until that packet's TAIL flit has been accepted downstream. The winner's flits are
//   muxed onto the output channel with valid/ready flow control.
//
// Optional feature: define MESH_ARB_BACK2BACK_EN to re-arbitrate on the TAIL transfer
//   cycle, so the next packet is granted without an idle bubble.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   in_data_i   input flits, port k at [k*CHANNEL_W +: CHANNEL_W]
//   in_vld_i    per-input flit valid
//   in_rdy_o    per-input ready (only the granted port can be ready)
//   out_data_o  flit to the downstream channel, 0 when nothing is granted
//   out_vld_o   output valid
//   out_rdy_i   downstream ready
//   grant_o     registered one-hot grant, all zero when idle
//   busy_o      high while a packet holds the lock
//   pkt_cnt_o   count of transferred TAIL flits, wraps
//   err_o       one-cycle pulse: HEAD or NULL flit seen from the locked port
module mesh_wormhole_out_arbiter #(
  parameter int unsigned IN_N      = 5,
  parameter int unsigned CHANNEL_W = 8,
  parameter int unsigned FLIT_ID_W = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [IN_N*CHANNEL_W-1:0] in_data_i,
  input  logic [IN_N-1:0]           in_vld_i,
  output logic [IN_N-1:0]           in_rdy_o,
  output logic [CHANNEL_W-1:0]      out_data_o,
  output logic                      out_vld_o,
  input  logic                      out_rdy_i,
  output logic [IN_N-1:0]           grant_o,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          pkt_cnt_o,
  output logic                      err_o
);

  localparam logic [FLIT_ID_W-1:0] IdNull = FLIT_ID_W'(0);
  localparam logic [FLIT_ID_W-1:0] IdHead = FLIT_ID_W'(1);
  localparam logic [FLIT_ID_W-1:0] IdTail = FLIT_ID_W'(3);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                     state_q;
  logic [IN_N-1:0]            grant_q;
  logic                       busy_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       err_q;
  // prio_q[i][j] = 1 means input i beats input j; diagonal is don't-care.
  logic [IN_N-1:0][IN_N-1:0]  prio_q;
  logic [IN_N-1:0][IN_N-1:0]  prio_upd;

  logic [IN_N-1:0]            head_req;
  logic [IN_N-1:0]            win_idle;
  logic [FLIT_ID_W-1:0]       out_id;
  logic                       xfer;
  logic                       tail_xfer;
  logic                       err_det;

  // k wins if it requests and no other requester has priority over it.
  function automatic logic [IN_N-1:0] matrix_win(input logic [IN_N-1:0]           req,
                                                 input logic [IN_N-1:0][IN_N-1:0] p);
    logic [IN_N-1:0] win;
    for (int k = 0; k < IN_N; k++) begin
      win[k] = req[k];
      for (int j = 0; j < IN_N; j++) begin
        if (j != k && req[j] && p[j][k]) win[k] = 1'b0;
      end
    end
    return win;
  endfunction

  always_comb begin
    head_req   = '0;
    out_data_o = '0;
    for (int k = 0; k < IN_N; k++) begin
      head_req[k] = in_vld_i[k] &&
                    (in_data_i[k*CHANNEL_W + CHANNEL_W - FLIT_ID_W +: FLIT_ID_W] == IdHead);
      // Grant is one-hot or zero, so OR-ing masked flits is a plain mux.
      if (grant_q[k]) out_data_o = out_data_o | in_data_i[k*CHANNEL_W +: CHANNEL_W];
    end
  end

  assign out_id    = out_data_o[CHANNEL_W-1 -: FLIT_ID_W];
  assign out_vld_o = |(in_vld_i & grant_q);
  assign in_rdy_o  = grant_q & {IN_N{out_rdy_i}};
  assign xfer      = out_vld_o & out_rdy_i;
  assign tail_xfer = xfer && (out_id == IdTail);
  assign err_det   = (state_q == StLocked) && out_vld_o &&
                     ((out_id == IdHead) || (out_id == IdNull));

  // Matrix after the granted port finishes: it drops to lowest priority.
  always_comb begin
    prio_upd = prio_q;
    for (int i = 0; i < IN_N; i++) begin
      for (int j = 0; j < IN_N; j++) begin
        if (grant_q[i])      prio_upd[i][j] = 1'b0;
        else if (grant_q[j]) prio_upd[i][j] = 1'b1;
      end
    end
  end

  assign win_idle = matrix_win(head_req, prio_q);

`ifdef MESH_ARB_BACK2BACK_EN
  logic [IN_N-1:0] win_b2b;
  assign win_b2b = matrix_win(head_req & ~grant_q, prio_upd);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < IN_N; i++) begin
        for (int j = 0; j < IN_N; j++) begin
          prio_q[i][j] <= (i < j);
        end
      end
    end else begin
      err_q <= err_det;
      case (state_q)
        StIdle: begin
          if (|head_req) begin
            grant_q <= win_idle;
            busy_q  <= 1'b1;
            state_q <= StLocked;
          end
        end
        StLocked: begin
          if (tail_xfer) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            prio_q <= prio_upd;
`ifdef MESH_ARB_BACK2BACK_EN
            if (|win_b2b) begin
              grant_q <= win_b2b;
            end else begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
`else
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
`endif
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign pkt_cnt_o = cnt_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mesh_wormhole_out_arbiter.sv
// Directed bench for mesh_wormhole_out_arbiter (IN_N=5, CHANNEL_W=8, FLIT_ID_W=2, CNT_W=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units later.
module tb_mesh_wormhole_out_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [39:0] in_data;
  logic [4:0]  in_vld;
  logic [4:0]  in_rdy;
  logic [7:0]  out_data;
  logic        out_vld;
  logic        out_rdy;
  logic [4:0]  grant;
  logic        busy;
  logic [7:0]  pkt_cnt;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  int         n_xfer;
  logic [7:0] xlog [16];

  mesh_wormhole_out_arbiter #(
    .IN_N      (5),
    .CHANNEL_W (8),
    .FLIT_ID_W (2),
    .CNT_W     (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_data_i  (in_data),
    .in_vld_i   (in_vld),
    .in_rdy_o   (in_rdy),
    .out_data_o (out_data),
    .out_vld_o  (out_vld),
    .out_rdy_i  (out_rdy),
    .grant_o    (grant),
    .busy_o     (busy),
    .pkt_cnt_o  (pkt_cnt),
    .err_o      (err)
  );

  always #5 clk_i = ~clk_i;

  // Log of flits accepted downstream, cleared by reset.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_xfer <= 0;
    end else if (out_vld && out_rdy) begin
      xlog[n_xfer[3:0]] <= out_data;
      n_xfer            <= n_xfer + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_port(input int k, input logic v, input logic [7:0] d);
    in_vld[k]        = v;
    in_data[k*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    in_vld  = '0;
    in_data = '0;
    out_rdy = 1'b1;
    #2;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", pkt_cnt, 0);
    rst_ni = 1'b1;
    #1;
  endtask

  // Send an n-flit packet (H, B.., T) on port k, following in_rdy.
  task automatic run_pkt(input int k, input int n);
    logic [1:0] id;
    bit         done;
    for (int i = 0; i < n; i++) begin
      id = (i == 0) ? 2'b01 : (i == n - 1) ? 2'b11 : 2'b10;
      set_port(k, 1'b1, {id, 6'(i)});
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        #1;
        if (in_rdy[k]) done = 1'b1;
        tick();
      end
      if (!done) check("pkt_tmo", 32'(done), 1);
    end
    set_port(k, 1'b0, 8'h00);
  endtask

  initial begin
    logic [4:0] ph;
    logic [4:0] xf;
    int         order [$];
    int         tails;

    // 1: single packet on port 2
    do_reset();
    check("t1_rst_err", err, 0);
    check("t1_rst_vld", out_vld, 0);
    set_port(2, 1'b1, 8'h41);
    #1;
    check("t1_rdy_pre", in_rdy, 0);
    check("t1_vld_pre", out_vld, 0);
    tick();
    check("t1_grant", grant, 5'b00100);
    check("t1_busy", busy, 1);
    check("t1_vld", out_vld, 1);
    check("t1_head", out_data, 8'h41);
    tick();
    set_port(2, 1'b1, 8'h82);
    #1;
    check("t1_body", out_data, 8'h82);
    tick();
    set_port(2, 1'b1, 8'h83);
    tick();
    set_port(2, 1'b1, 8'hC4);
    #1;
    check("t1_tail", out_data, 8'hC4);
    check("t1_busy_t", busy, 1);
    tick();
    set_port(2, 1'b0, 8'h00);
    #1;
    check("t1_grant_end", grant, 0);
    check("t1_busy_end", busy, 0);
    check("t1_cnt", pkt_cnt, 1);
    check("t1_nxfer", n_xfer, 4);
    check("t1_log1", xlog[1], 8'h82);
    check("t1_log3", xlog[3], 8'hC4);

    // 2: simultaneous HEADs on ports 1 and 3
    do_reset();
    set_port(1, 1'b1, 8'h51);
    set_port(3, 1'b1, 8'h53);
    tick();
    check("t2_grant1", grant, 5'b00010);
    check("t2_data1", out_data, 8'h51);
    tick();
    set_port(1, 1'b1, 8'hD1);
    #1;
    check("t2_rdy", in_rdy, 5'b00010);
    tick();
    set_port(1, 1'b0, 8'h00);
    #1;
    check("t2_cnt", pkt_cnt, 1);
`ifdef MESH_ARB_BACK2BACK_EN
    check("t2_b2b_grant", grant, 5'b01000);
    check("t2_b2b_busy", busy, 1);
`else
    check("t2_bubble_grant", grant, 0);
    check("t2_bubble_busy", busy, 0);
    tick();
    check("t2_grant3", grant, 5'b01000);
`endif
    check("t2_data3", out_data, 8'h53);

    // 3: all ports stream 2-flit packets
    do_reset();
    ph    = '0;
    tails = 0;
    for (int c = 0; c < 100 && tails < 10; c++) begin
      for (int k = 0; k < 5; k++) set_port(k, 1'b1, {ph[k] ? 2'b11 : 2'b01, 6'(k)});
      #1;
      xf = in_rdy & in_vld;
      for (int k = 0; k < 5; k++) begin
        if (xf[k]) begin
          if (!ph[k]) order.push_back(k);
          else        tails++;
        end
      end
      tick();
      ph = ph ^ xf;
    end
    check("t3_cnt", pkt_cnt, 10);
    check("t3_npkt", order.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_order%0d", i), (i < order.size()) ? order[i] : -1, i % 5);
    end

    // 4: downstream stall while locked on port 0
    do_reset();
    set_port(0, 1'b1, 8'h40);
    tick();
    tick();
    set_port(0, 1'b1, 8'h8A);
    out_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("t4_rdy%0d", c), in_rdy, 0);
      check($sformatf("t4_grant%0d", c), grant, 5'b00001);
      check($sformatf("t4_data%0d", c), out_data, 8'h8A);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    check("t4_rdy_go", in_rdy, 5'b00001);
    tick();
    set_port(0, 1'b1, 8'hCB);
    tick();
    set_port(0, 1'b0, 8'h00);
    #1;
    check("t4_nxfer", n_xfer, 3);
    check("t4_log0", xlog[0], 8'h40);
    check("t4_log1", xlog[1], 8'h8A);
    check("t4_log2", xlog[2], 8'hCB);
    check("t4_cnt", pkt_cnt, 1);

    // 5: HEAD ID mid-packet on locked port 4
    do_reset();
    set_port(4, 1'b1, 8'h44);
    tick();
    check("t5_grant", grant, 5'b10000);
    tick();
    set_port(4, 1'b1, 8'h85);
    tick();
    set_port(4, 1'b1, 8'h46);
    #1;
    check("t5_err_pre", err, 0);
    tick();
    set_port(4, 1'b1, 8'hC7);
    #1;
    check("t5_err", err, 1);
    check("t5_grant_held", grant, 5'b10000);
    check("t5_busy_held", busy, 1);
    check("t5_fwd", xlog[2], 8'h46);
    tick();
    set_port(4, 1'b0, 8'h00);
    #1;
    check("t5_err_clr", err, 0);
    check("t5_grant_end", grant, 0);
    check("t5_cnt", pkt_cnt, 1);

    // 6: reset mid-packet restores reset priority; then counter wrap
    do_reset();
    run_pkt(0, 2);
    set_port(1, 1'b1, 8'h41);
    tick();
    tick();
    check("t6_locked", grant, 5'b00010);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_grant", grant, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cnt", pkt_cnt, 0);
    set_port(1, 1'b0, 8'h00);
    rst_ni = 1'b1;
    set_port(0, 1'b1, 8'h40);
    set_port(3, 1'b1, 8'h43);
    tick();
    check("t6_prio_reset", grant, 5'b00001);
    run_pkt(0, 2);
`ifndef MESH_ARB_BACK2BACK_EN
    tick();
`endif
    check("t6_grant3", grant, 5'b01000);
    run_pkt(3, 2);

    do_reset();
    for (int p = 0; p < 255; p++) run_pkt(1, 2);
    check("t6_cnt255", pkt_cnt, 255);
    run_pkt(1, 2);
    check("t6_wrap", pkt_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
